// File: rtl/noc_pkg.sv
// Shared NoC types: flit format, flit labels, per-VC state and VC count.
// Sized for a two-VC router with 16-bit payloads.
package noc_pkg;

    localparam int unsigned VC_NUM    = 2;
    localparam int unsigned VC_ID_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int unsigned PAYLOAD_W = 16;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef enum logic [1:0] {IDLE, RECEIVING, DRAINING} vc_state_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_ID_W-1:0]   vc_id;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    function automatic logic is_head(input flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

endpackage

// File: rtl/router2router.sv
// Router-to-router link: flit forward path plus per-VC on/off and allocatable
// feedback from the downstream input buffer.
interface router2router;
    import noc_pkg::*;

    flit_t              data;
    logic               is_valid;
    logic [VC_NUM-1:0]  is_on_off;
    logic [VC_NUM-1:0]  is_allocatable;

    modport upstream (
        output data, is_valid,
        input  is_on_off, is_allocatable
    );

    modport downstream (
        input  data, is_valid,
        output is_on_off, is_allocatable
    );

endinterface

// File: rtl/circular_buffer.sv
// Single-VC circular flit FIFO; a write to a full buffer is accepted only when
// a read frees a slot in the same cycle.
module circular_buffer
    import noc_pkg::*;
#(
    parameter  int unsigned BUFFER_SIZE = 8,
    localparam int unsigned PTR_W       = $clog2(BUFFER_SIZE),
    localparam int unsigned CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_i,
    input  flit_t            data_i,
    input  logic             read_i,
    output flit_t            flit_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    flit_t            mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, do_read, do_write;

    assign empty_o  = (count_q == '0);
    assign full     = (count_q == CNT_W'(BUFFER_SIZE));
    assign do_read  = read_i && !empty_o;
    assign do_write = write_i && (!full || do_read);
    assign flit_o   = mem_q[rd_ptr_q];
    assign count_o  = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_read)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_write) - CNT_W'(do_read);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/vc_input_buffer.sv
// Per-input-port VC buffer: one FIFO per VC, packet-label FSMs, on/off flow control.
// Define VC_INPUT_BUFFER_CHECK_EN to build the sticky protocol/overflow error flag.
module vc_input_buffer
    import noc_pkg::*;
#(
    parameter  int unsigned BUFFER_SIZE   = 8,
    parameter  int unsigned OFF_THRESHOLD = 2,
    parameter  int unsigned ON_THRESHOLD  = 4,
    localparam int unsigned CNT_W         = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    router2router.downstream         router_if,
    input  logic      [VC_NUM-1:0]   read_i,
    output flit_t     [VC_NUM-1:0]   flit_o,
    output logic      [VC_NUM-1:0]   valid_o,
    output logic                     error_o
);

    logic [VC_NUM-1:0] wr, rd, acc, empty;
    logic [CNT_W-1:0]  count   [VC_NUM];
    logic [CNT_W-1:0]  count_d [VC_NUM];
    vc_state_t         state_q [VC_NUM];
    vc_state_t         state_d [VC_NUM];
    logic [VC_NUM-1:0] on_off_q, on_off_d, alloc_q;
    logic [CNT_W-1:0]  free;

    for (genvar gv = 0; gv < VC_NUM; gv++) begin : g_vc
        assign wr[gv] = router_if.is_valid && (router_if.data.vc_id == VC_ID_W'(gv));

        circular_buffer #(
            .BUFFER_SIZE (BUFFER_SIZE)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .write_i (wr[gv]),
            .data_i  (router_if.data),
            .read_i  (read_i[gv]),
            .flit_o  (flit_o[gv]),
            .count_o (count[gv]),
            .empty_o (empty[gv])
        );
    end

    assign valid_o                  = ~empty;
    assign router_if.is_on_off      = on_off_q;
    assign router_if.is_allocatable = alloc_q;

    always_comb begin
        rd       = '0;
        acc      = '0;
        on_off_d = on_off_q;
        free     = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            rd[v]      = read_i[v] && !empty[v];
            acc[v]     = wr[v] && ((count[v] != CNT_W'(BUFFER_SIZE)) || rd[v]);
            count_d[v] = count[v] + CNT_W'(acc[v]) - CNT_W'(rd[v]);
            free       = CNT_W'(BUFFER_SIZE) - count_d[v];
            if (free <= CNT_W'(OFF_THRESHOLD))     on_off_d[v] = 1'b0;
            else if (free >= CNT_W'(ON_THRESHOLD)) on_off_d[v] = 1'b1;

            state_d[v] = state_q[v];
            unique case (state_q[v])
                IDLE: begin
                    if (acc[v] && is_head(router_if.data.flit_label)) begin
                        state_d[v] = (router_if.data.flit_label == HEAD) ? RECEIVING : DRAINING;
                    end
                end
                RECEIVING: begin
                    if (acc[v] && router_if.data.flit_label == TAIL) state_d[v] = DRAINING;
                end
                DRAINING: begin
                    if (count_d[v] == '0) state_d[v] = IDLE;
                end
                default: state_d[v] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) state_q[v] <= IDLE;
            on_off_q <= '1;
            alloc_q  <= '1;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= state_d[v];
                alloc_q[v] <= (state_d[v] == IDLE);
            end
            on_off_q <= on_off_d;
        end
    end

`ifdef VC_INPUT_BUFFER_CHECK_EN
    logic error_q, error_d;

    // Label error: a head in a busy VC, or a non-head opening an idle VC.
    always_comb begin
        error_d = error_q;
        for (int v = 0; v < VC_NUM; v++) begin
            if ((wr[v] && !acc[v]) || (read_i[v] && empty[v]) ||
                (wr[v] && ((state_q[v] == IDLE) != is_head(router_if.data.flit_label)))) begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) error_q <= 1'b0;
        else     error_q <= error_d;
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule
